rgb_gray_frame_ctrl: RTL and testbench
======================================

Name: rgb_gray_frame_ctrl

Overview:
- Frame-level controller that sequences a stream of packed RGB pixels through one combinational RGB_mean instance, producing a grayscale pixel stream.
- Provides valid/ready handshakes on both sides and a one-stage registered output.
- Tracks pixel and line position, tags start-of-frame, end-of-line and end-of-frame, and pulses frame_done once the last gray pixel is consumed.
- Sits between the RGB pixel source and the downstream grayscale consumers.

Parameters:
- DATA_WIDTH, 8, width of one colour channel and of the gray output.
- FRAME_WIDTH, 320, pixels per line.
- FRAME_HEIGHT, 240, lines per frame.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- s_valid  input  1  upstream RGB pixel valid.
- s_ready  output  1  controller accepts a pixel this cycle.
- s_data  input  3*DATA_WIDTH  packed pixel {B,G,R}, R in bits [DATA_WIDTH-1:0].
- m_valid  output  1  gray pixel valid.
- m_ready  input  1  downstream accepts a gray pixel.
- m_data  output  DATA_WIDTH  gray pixel, floor((R+G+B)/3).
- m_sof  output  1  m_data is the first pixel of the frame.
- m_eol  output  1  m_data is the last pixel of a line.
- m_eof  output  1  m_data is the last pixel of the frame.
- busy  output  1  high in ACTIVE or DRAIN.
- frame_done  output  1  one-cycle pulse when the frame is fully delivered.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. All outputs reset to 0; state resets to IDLE; counters reset to 0.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE on start=1. Pixel and line counters clear on this transition.
  - ACTIVE -> DRAIN on the cycle the last pixel (FRAME_WIDTH*FRAME_HEIGHT-th) is accepted.
  - DRAIN -> IDLE when the output register is empty, or empties this cycle (m_valid & m_ready). frame_done=1 in that same cycle.
  - start is ignored outside IDLE, including in the cycle frame_done pulses.
- Accept: s_fire = s_valid & s_ready.
  - s_ready = (state==ACTIVE) & (~m_valid | m_ready). This allows full throughput of 1 pixel/clk with no bubble while downstream is ready.
  - RGB_mean en is driven by s_fire. Its quotient is captured into m_data only on s_fire, so the gated-zero output is never registered.
- Latency: exactly 1 clk from s_fire to m_valid=1 with the corresponding m_data.
- Output register:
  - Loads on s_fire and sets m_valid=1.
  - On m_valid & m_ready without s_fire, m_valid clears.
  - If both occur in the same cycle, the new pixel replaces the old one with m_valid held at 1.
  - m_data, m_sof, m_eol and m_eof are stable while m_valid & ~m_ready.
- Tags, computed from the counters at s_fire and registered with m_data:
  - m_sof: pixel 0 of line 0.
  - m_eol: column == FRAME_WIDTH-1.
  - m_eof: column == FRAME_WIDTH-1 and line == FRAME_HEIGHT-1.
- Counters:
  - Column counter is $clog2(FRAME_WIDTH) bits; it wraps to 0 at FRAME_WIDTH-1 and increments the line counter.
  - Line counter is $clog2(FRAME_HEIGHT) bits.
  - No counter wraps beyond the frame, because s_ready is low in DRAIN.
- Arithmetic: the sum is DATA_WIDTH+2 bits, so there is no overflow. The divide is floor division. Max input 3*255 -> 255.
- Reset mid-frame: returns to IDLE immediately. Any pending output is dropped (m_valid=0) and no frame_done is issued.
- frame_done and an in-range start never coincide with ACTIVE; back-to-back frames need start in a cycle after frame_done.

Optional Feature:
- Macro: RGB_GRAY_FRAME_STATS_EN.
- When defined:
  - Adds outputs frame_sum (DATA_WIDTH+$clog2(FRAME_WIDTH*FRAME_HEIGHT) bits), frame_max (DATA_WIDTH) and frame_min (DATA_WIDTH).
  - Accumulation happens on each s_fire.
  - The accumulators clear on the IDLE->ACTIVE transition, to sum=0, max=0, min=all-ones.
  - The registered outputs update in the frame_done cycle and hold until the next frame_done; they reset to 0.
- When undefined: these ports and all related logic are absent.

Decomposition:
- Shared package rgb_gray_pkg holds:
  - Typedef ctrl_state_t {IDLE, ACTIVE, DRAIN}.
  - Localparam DATA_WIDTH_DEF=8.
  - A packed struct gray_beat_t {data, sof, eol, eof} for the output register.
- The only sub-module is the existing RGB_mean instance, named u_rgb_mean. No further hierarchy.

Test Plan (FRAME_WIDTH=4, FRAME_HEIGHT=2 overrides):
- Reset: hold rst 3 clks with s_valid=1 -> all outputs 0, s_ready=0. Then start pulse -> s_ready=1 next clk.
- Full rate: 8 pixels, m_ready=1; pixel0 R=30,G=60,B=90, pixel7=0xFFFFFF, others {0,1,1}.
  - m_data is 60 one clk after the first accept, with m_sof=1.
  - The others give m_data=0 (floor 2/3); pixel7 gives 255.
  - m_eol on pixels 3 and 7; m_eof on pixel 7.
  - frame_done pulses once, on the clk after pixel7 transfers. busy=0 after.
- Backpressure: m_ready=0 for 5 clks mid-frame -> s_ready=0 and m_data/tags held stable. On release, no pixel is lost or duplicated (8 outputs total).
- Ignored start: start pulsed during ACTIVE and in the frame_done cycle -> no counter clear and no new frame until start is reasserted in IDLE.
- Reset mid-frame after 5 pixels -> state IDLE, m_valid=0, no frame_done. A new start and 8 pixels produce a correct frame with m_sof on the first pixel.
- STATS_EN: frame values 0,3,6,...,21 gray-equivalent -> frame_sum=84, frame_max=21, frame_min=0, valid at the frame_done cycle.

Source files
------------

// File: rtl/rgb_gray_frame_ctrl_pkg.sv
// Shared types for the RGB-to-gray frame controller: FSM states and the
// registered output beat.
package rgb_gray_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } ctrl_state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      sof;
    logic                      eol;
    logic                      eof;
  } gray_beat_t;

endpackage

// File: rtl/rgb_gray_frame_ctrl_mean.sv
// Combinational channel mean of a packed {B,G,R} pixel: floor((R+G+B)/3),
// forced to zero when en is low.
module RGB_mean #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    en,
  input  logic [3*DATA_WIDTH-1:0] rgb,
  output logic [DATA_WIDTH-1:0]   mean
);

  logic [DATA_WIDTH+1:0] sum;

  always_comb begin
    sum = {2'b00, rgb[DATA_WIDTH-1:0]}
        + {2'b00, rgb[2*DATA_WIDTH-1:DATA_WIDTH]}
        + {2'b00, rgb[3*DATA_WIDTH-1:2*DATA_WIDTH]};
    // The quotient never exceeds the channel maximum, so truncation is exact.
    mean = en ? DATA_WIDTH'(sum / (DATA_WIDTH+2)'(3)) : '0;
  end

endmodule

// File: rtl/rgb_gray_frame_ctrl.sv
// Frame controller streaming packed RGB pixels through RGB_mean into a tagged
// grayscale stream. Optional per-frame statistics: RGB_GRAY_FRAME_STATS_EN.
module rgb_gray_frame_ctrl
  import rgb_gray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned FRAME_WIDTH  = 320,
  parameter int unsigned FRAME_HEIGHT = 240
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3*DATA_WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic                    m_eof,
  output logic                    busy,
  output logic                    frame_done
`ifdef RGB_GRAY_FRAME_STATS_EN
  ,
  output logic [DATA_WIDTH+$clog2(FRAME_WIDTH*FRAME_HEIGHT)-1:0] frame_sum,
  output logic [DATA_WIDTH-1:0]   frame_max,
  output logic [DATA_WIDTH-1:0]   frame_min
`endif
);

  localparam int unsigned COL_W  = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int unsigned LINE_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(FRAME_WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_HEIGHT - 1);

  if (DATA_WIDTH != DATA_WIDTH_DEF) begin : g_width_check
    $error("rgb_gray_frame_ctrl: DATA_WIDTH must match rgb_gray_pkg::DATA_WIDTH_DEF");
  end

  ctrl_state_t       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  gray_beat_t        beat_q, beat_d;
  logic              m_valid_q, m_valid_d;
  logic              frame_done_q, frame_done_d;

  logic                  s_ready_c;
  logic                  s_fire;
  logic                  last_col;
  logic                  last_line;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] gray;

  RGB_mean #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rgb_mean (
    .en  (s_fire),
    .rgb (s_data),
    .mean(gray)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    beat_d       = beat_q;
    m_valid_d    = m_valid_q;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;

    s_ready_c = (state_q == ACTIVE) && (!m_valid_q || m_ready);
    s_fire    = s_valid && s_ready_c;
    last_col  = (col_q == COL_LAST);
    last_line = (line_q == LINE_LAST);

    unique case (state_q)
      IDLE: begin
        // frame_done is registered, so its pulse cycle is already IDLE;
        // start must still be ignored there.
        if (start && !frame_done_q) begin
          state_d     = ACTIVE;
          col_d       = '0;
          line_d      = '0;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (s_fire && last_col && last_line) state_d = DRAIN;
      end
      DRAIN: begin
        if (!m_valid_q || m_ready) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (s_fire) begin
      if (last_col) begin
        col_d  = '0;
        line_d = last_line ? '0 : line_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      beat_d = '{data: gray,
                 sof:  (col_q == '0) && (line_q == '0),
                 eol:  last_col,
                 eof:  last_col && last_line};
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      line_q       <= '0;
      beat_q       <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      m_valid_q    <= m_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = s_ready_c;
  assign m_valid    = m_valid_q;
  assign m_data     = beat_q.data;
  assign m_sof      = beat_q.sof;
  assign m_eol      = beat_q.eol;
  assign m_eof      = beat_q.eof;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

`ifdef RGB_GRAY_FRAME_STATS_EN
  localparam int unsigned SUM_W = DATA_WIDTH + $clog2(FRAME_WIDTH * FRAME_HEIGHT);

  logic [SUM_W-1:0]      acc_sum_q, acc_sum_d;
  logic [DATA_WIDTH-1:0] acc_max_q, acc_max_d;
  logic [DATA_WIDTH-1:0] acc_min_q, acc_min_d;
  logic [SUM_W-1:0]      frame_sum_q, frame_sum_d;
  logic [DATA_WIDTH-1:0] frame_max_q, frame_max_d;
  logic [DATA_WIDTH-1:0] frame_min_q, frame_min_d;

  always_comb begin
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    acc_min_d   = acc_min_q;
    frame_sum_d = frame_sum_q;
    frame_max_d = frame_max_q;
    frame_min_d = frame_min_q;
    if (frame_start) begin
      acc_sum_d = '0;
      acc_max_d = '0;
      acc_min_d = '1;
    end else if (s_fire) begin
      acc_sum_d = acc_sum_q + SUM_W'(gray);
      if (gray > acc_max_q) acc_max_d = gray;
      if (gray < acc_min_q) acc_min_d = gray;
    end
    // The last pixel fired before DRAIN, so the accumulators are complete here.
    if (frame_done_d) begin
      frame_sum_d = acc_sum_q;
      frame_max_d = acc_max_q;
      frame_min_d = acc_min_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_min_q   <= '1;
      frame_sum_q <= '0;
      frame_max_q <= '0;
      frame_min_q <= '0;
    end else begin
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      acc_min_q   <= acc_min_d;
      frame_sum_q <= frame_sum_d;
      frame_max_q <= frame_max_d;
      frame_min_q <= frame_min_d;
    end
  end

  assign frame_sum = frame_sum_q;
  assign frame_max = frame_max_q;
  assign frame_min = frame_min_q;
`endif

endmodule

// File: tb/tb_rgb_gray_frame_ctrl.sv
// Directed bench for rgb_gray_frame_ctrl on a 4x2 frame: reset, full rate,
// backpressure, ignored start, mid-frame reset and optional statistics.
module tb_rgb_gray_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_eof;
  logic        busy;
  logic        frame_done;
`ifdef RGB_GRAY_FRAME_STATS_EN
  logic [10:0] frame_sum;
  logic [7:0]  frame_max;
  logic [7:0]  frame_min;
`endif

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int base;

  always #5 clk = ~clk;

  always @(posedge clk) if (m_valid && m_ready) xfer_cnt++;

  rgb_gray_frame_ctrl #(
    .DATA_WIDTH  (8),
    .FRAME_WIDTH (4),
    .FRAME_HEIGHT(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_eof     (m_eof),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef RGB_GRAY_FRAME_STATS_EN
    ,
    .frame_sum (frame_sum),
    .frame_max (frame_max),
    .frame_min (frame_min)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_s_ready", s_ready, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic pixel(input logic [23:0] d, input logic [7:0] g, input int idx);
    s_valid = 1'b1;
    s_data  = d;
    step();
    chk("px_valid", m_valid, 1);
    chk("px_data", m_data, g);
    chk("px_sof", m_sof, (idx == 0) ? 1 : 0);
    chk("px_eol", m_eol, (idx % 4 == 3) ? 1 : 0);
    chk("px_eof", m_eof, (idx == 7) ? 1 : 0);
  endtask

  task automatic drain(input bit poke_start, input int exp_sum, input int exp_max,
                       input int exp_min);
    s_valid = 1'b0;
    chk("drain_s_ready", s_ready, 0);
    chk("drain_busy", busy, 1);
    step();
    chk("done_pulse", frame_done, 1);
    chk("done_busy", busy, 0);
    chk("done_m_valid", m_valid, 0);
`ifdef RGB_GRAY_FRAME_STATS_EN
    chk("stats_sum", frame_sum, exp_sum);
    chk("stats_max", frame_max, exp_max);
    chk("stats_min", frame_min, exp_min);
`endif
    if (poke_start) start = 1'b1;
    step();
    start = 1'b0;
    chk("done_clear", frame_done, 0);
    chk("after_done_busy", busy, 0);
    chk("after_done_s_ready", s_ready, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 24'hFFFFFF;
    m_ready = 1'b1;
    repeat (3) step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sof", m_sof, 0);
    chk("rst_m_eol", m_eol, 0);
    chk("rst_m_eof", m_eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);

    rst     = 1'b0;
    s_valid = 1'b0;
    step();
    chk("idle_s_ready", s_ready, 0);

    // Full-rate frame; start poked in the frame_done cycle must be ignored.
    begin_frame();
    base = xfer_cnt;
    pixel({8'd90, 8'd60, 8'd30}, 8'd60, 0);
    for (int i = 1; i < 7; i++) pixel(24'h000101, 8'd0, i);
    pixel(24'hFFFFFF, 8'd255, 7);
    drain(1'b1, 315, 255, 0);
    chk("full_xfers", xfer_cnt - base, 8);
    step();
    chk("ignored_start_busy", busy, 0);

    // Backpressure after the first line; start poked while ACTIVE.
    begin_frame();
    base = xfer_cnt;
    for (int i = 0; i < 4; i++) pixel({3{8'(10 + i)}}, 8'(10 + i), i);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = {3{8'd14}};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 13);
      chk("bp_m_eol", m_eol, 1);
      chk("bp_m_sof", m_sof, 0);
    end
    m_ready = 1'b1;
    pixel({3{8'd14}}, 8'd14, 4);
    start = 1'b1;
    pixel({3{8'd15}}, 8'd15, 5);
    start = 1'b0;
    pixel({3{8'd16}}, 8'd16, 6);
    pixel({3{8'd17}}, 8'd17, 7);
    drain(1'b0, 108, 17, 10);
    chk("bp_xfers", xfer_cnt - base, 8);

    // Reset after 5 pixels with the output held pending.
    begin_frame();
    for (int i = 0; i < 5; i++) pixel(24'h030303, 8'd3, i);
    m_ready = 1'b0;
    s_valid = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_frame_done", frame_done, 0);
    step();
    chk("midrst_no_done", frame_done, 0);
    m_ready = 1'b1;

    // Recovery frame with grays 0,3,...,21.
    begin_frame();
    base = xfer_cnt;
    for (int i = 0; i < 8; i++) pixel({3{8'(3 * i)}}, 8'(3 * i), i);
    drain(1'b0, 84, 21, 0);
    chk("recover_xfers", xfer_cnt - base, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
